// File: rtl/hazard_unit.sv
// Stall and forwarding control for the five-stage MIPS pipeline.
// Shadows each in-flight writer's destination and remaining Tnew through E, M and W.
module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [1:0]       Tuse_rs,
    input  logic [1:0]       Tuse_rt,
    input  logic [4:0]       A3_D,
    input  logic [1:0]       Tnew_D,
    output logic             stall,
    output logic [1:0]       FwdRsD,
    output logic [1:0]       FwdRtD,
    output logic [1:0]       FwdRsE,
    output logic [1:0]       FwdRtE,
    output logic             FwdRtM,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [4:0] rs_E, rt_E, A3_E;
    logic [1:0] Tnew_E;
    logic [4:0] rt_M, A3_M;
    logic [1:0] Tnew_M;
    logic [4:0] A3_W;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // A reader must wait while a matching writer in E or M still needs more cycles than it can spare.
    function automatic logic hazard(input logic [4:0] r, input logic [1:0] tuse,
                                    input logic [4:0] a3e, input logic [1:0] tne,
                                    input logic [4:0] a3m, input logic [1:0] tnm);
        return (r != 5'd0) && (((r == a3e) && (tne > tuse)) || ((r == a3m) && (tnm > tuse)));
    endfunction

    function automatic logic [1:0] fwd_d(input logic [4:0] r,
                                         input logic [4:0] a3e, input logic [1:0] tne,
                                         input logic [4:0] a3m, input logic [1:0] tnm,
                                         input logic [4:0] a3w);
        if (r == 5'd0)                      return 2'b00;
        else if (r == a3e && tne == 2'd0)   return 2'b11;
        else if (r == a3m && tnm == 2'd0)   return 2'b10;
        else if (r == a3w)                  return 2'b01;
        else                                return 2'b00;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] r,
                                         input logic [4:0] a3m, input logic [1:0] tnm,
                                         input logic [4:0] a3w);
        if (r == 5'd0)                      return 2'b00;
        else if (r == a3m && tnm == 2'd0)   return 2'b10;
        else if (r == a3w)                  return 2'b01;
        else                                return 2'b00;
    endfunction

    always_comb begin
        stall  = hazard(rs_D, Tuse_rs, A3_E, Tnew_E, A3_M, Tnew_M)
               | hazard(rt_D, Tuse_rt, A3_E, Tnew_E, A3_M, Tnew_M);
        FwdRsD = fwd_d(rs_D, A3_E, Tnew_E, A3_M, Tnew_M, A3_W);
        FwdRtD = fwd_d(rt_D, A3_E, Tnew_E, A3_M, Tnew_M, A3_W);
        FwdRsE = fwd_e(rs_E, A3_M, Tnew_M, A3_W);
        FwdRtE = fwd_e(rt_E, A3_M, Tnew_M, A3_W);
        FwdRtM = (rt_M != 5'd0) && (rt_M == A3_W);
    end

    // Shadow stages D->E, E->M, M->W; a stall injects an all-zero bubble into E.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_E      <= '0;
            rt_E      <= '0;
            A3_E      <= '0;
            Tnew_E    <= '0;
            rt_M      <= '0;
            A3_M      <= '0;
            Tnew_M    <= '0;
            A3_W      <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall) begin
                rs_E   <= '0;
                rt_E   <= '0;
                A3_E   <= '0;
                Tnew_E <= '0;
            end else begin
                rs_E   <= rs_D;
                rt_E   <= rt_D;
                A3_E   <= A3_D;
                Tnew_E <= Tnew_D;
            end
            rt_M   <= rt_E;
            A3_M   <= A3_E;
            Tnew_M <= sat_dec(Tnew_E);
            A3_W   <= A3_M;
            if (stall)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the driver queues hand-computed expectations per cycle,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [4:0]       rs_D = '0, rt_D = '0, A3_D = '0;
    logic [1:0]       Tuse_rs = 2'd3, Tuse_rt = 2'd3, Tnew_D = '0;
    logic             stall;
    logic [1:0]       FwdRsD, FwdRtD, FwdRsE, FwdRtE;
    logic             FwdRtM;
    logic [CNT_W-1:0] stall_cnt;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
        .A3_D(A3_D), .Tnew_D(Tnew_D),
        .stall(stall), .FwdRsD(FwdRsD), .FwdRtD(FwdRtD),
        .FwdRsE(FwdRsE), .FwdRtE(FwdRtE), .FwdRtM(FwdRtM),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             s;
        logic [1:0]       rsd, rtd, rse, rte;
        logic             rtm;
        logic [CNT_W-1:0] cnt;
        logic             cf;
    } exp_t;

    exp_t  sb[$];
    string nq[$];
    int    n_checks = 0;
    int    n_err    = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    bit    drv_done = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compares whatever expectation the driver queued for this cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t  e;
            string nm;
            e  = sb.pop_front();
            nm = nq.pop_front();
            chk(nm, "stall", {31'd0, stall}, {31'd0, e.s});
            chk(nm, "stall_cnt", 32'(stall_cnt), 32'(e.cnt));
            if (e.cf) begin
                chk(nm, "FwdRsD", {30'd0, FwdRsD}, {30'd0, e.rsd});
                chk(nm, "FwdRtD", {30'd0, FwdRtD}, {30'd0, e.rtd});
                chk(nm, "FwdRsE", {30'd0, FwdRsE}, {30'd0, e.rse});
                chk(nm, "FwdRtE", {30'd0, FwdRtE}, {30'd0, e.rte});
                chk(nm, "FwdRtM", {31'd0, FwdRtM}, {31'd0, e.rtm});
            end
        end
    end

    task automatic issue(input string nm, input logic rst,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tur, input logic [1:0] tut,
                         input logic [4:0] a3, input logic [1:0] tn,
                         input logic s, input logic [1:0] frsd, input logic [1:0] frtd,
                         input logic [1:0] frse, input logic [1:0] frte, input logic frtm,
                         input logic cf);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; rs_D = rs; rt_D = rt; Tuse_rs = tur; Tuse_rt = tut; A3_D = a3; Tnew_D = tn;
        e = '{s: s, rsd: frsd, rtd: frtd, rse: frse, rte: frte, rtm: frtm, cnt: exp_cnt, cf: cf};
        sb.push_back(e);
        nq.push_back(nm);
        if (rst)
            exp_cnt = '0;
        else if (s && exp_cnt != '1)
            exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++)
            issue("flush", 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        @(posedge clk);
        // Reset behaviour: outputs cleared regardless of D inputs
        issue("rst_hold", 1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        issue("rst_idle", 0, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        flush();
        // lw $8 then addu reading $8 (Tuse=1): one stall, then W forward into E
        issue("lw_a",     0, 29, 8, 1, 3, 8, 2, 0, 0, 0, 0, 0, 0, 1);
        issue("lwuse_s",  0, 8, 9, 1, 1, 10, 1, 1, 0, 0, 0, 0, 0, 0);
        issue("lwuse_go", 0, 8, 9, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 1);
        issue("lwuse_fe", 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        flush();
        // lw $8 then beq $8 (Tuse=0): two stalls, then W forward into D
        issue("lw_b",     0, 29, 8, 1, 3, 8, 2, 0, 0, 0, 0, 0, 0, 1);
        issue("lwbr_s1",  0, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        issue("lwbr_s2",  0, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        issue("lwbr_go",  0, 8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        flush();
        // ori $9 then sw $9: no stall, M forward into E then W forward into M
        issue("ori",      0, 4, 9, 1, 3, 9, 1, 0, 0, 0, 0, 0, 0, 1);
        issue("sw",       0, 29, 9, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        issue("sw_fe",    0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 2, 0, 1);
        issue("sw_fm",    0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        flush();
        // jal then jr $31: E forward into D without stalling
        issue("jal",      0, 0, 0, 3, 3, 31, 0, 0, 0, 0, 0, 0, 0, 1);
        issue("jr",       0, 31, 0, 0, 3, 0, 0, 0, 3, 0, 0, 0, 0, 1);
        flush();
        // Writes to $0 are never forwarded nor stalled on
        issue("wr0",      0, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        issue("rd0",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        flush();
        // Matches in both E and M: E forward wins
        issue("dup_a",    0, 0, 0, 3, 3, 7, 0, 0, 0, 0, 0, 0, 0, 1);
        issue("dup_b",    0, 0, 0, 3, 3, 7, 0, 0, 0, 0, 0, 0, 0, 1);
        issue("dup_rd",   0, 7, 7, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 1);
        flush();
        // Reset asserted during a stall clears it and the counter
        issue("lw_c",     0, 29, 8, 1, 3, 8, 2, 0, 0, 0, 0, 0, 0, 1);
        issue("rst_stl",  1, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        issue("rst_aft",  0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        flush();
        // Self-dependent load-like op stalls two of every three cycles; counter saturates
        for (int i = 0; i < 8; i++) begin
            issue("sat_go",  0, 8, 0, 0, 3, 8, 2, 0, 0, 0, 0, 0, 0, 0);
            issue("sat_s1",  0, 8, 0, 0, 3, 8, 2, 1, 0, 0, 0, 0, 0, 0);
            issue("sat_s2",  0, 8, 0, 0, 3, 8, 2, 1, 0, 0, 0, 0, 0, 0);
        end
        issue("sat_end",  0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv_done = 1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!drv_done && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        repeat (3) @(posedge clk);
        n_checks++;
        if (!drv_done || sb.size() != 0) begin
            n_err++;
            $display("FAIL drain actual=%0d pending expected=0 pending (driver_done=%0d)", sb.size(), drv_done);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Central stall and forwarding unit for the five-stage MIPS pipeline. It receives the per-instruction hazard fields that the decoder produces in D: source registers, destination register, Tuse and Tnew. It tracks each in-flight writer's destination and remaining Tnew through E, M and W in its own shadow stage registers. From these it drives the D-stage stall and the forward-mux selects for the D, E and M stages, and keeps a saturating stall-cycle counter for diagnostics.

## Interface
Parameters:
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rs_D  in  5  rs field of the instruction in D.
- rt_D  in  5  rt field of the instruction in D.
- Tuse_rs  in  2  cycles until D uses rs; 3 = rs not read.
- Tuse_rt  in  2  cycles until D uses rt; 3 = rt not read.
- A3_D  in  5  destination register of the D instruction; 0 = no write.
- Tnew_D  in  2  cycles, counted from E entry, until the result exists (0..2).
- stall  out  1  freeze PC and the IF/ID register; insert a bubble into ID/EX.
- FwdRsD  out  2  D-stage rs source select.
- FwdRtD  out  2  D-stage rt source select.
- FwdRsE  out  2  E-stage rs source select.
- FwdRtE  out  2  E-stage rt source select.
- FwdRtM  out  1  M-stage rt (DM write data) source select.
- stall_cnt  out  CNT_W  total stall cycles since reset; saturates at all-ones.

Forward select encoding: 00 = own pipeline register value, 01 = W result, 10 = M result, 11 = E result. FwdRtM: 0 = pipeline value, 1 = W result.

## Operation
Shadow stage registers:
- E stage holds rs_E, rt_E, A3_E and Tnew_E.
- M stage holds rt_M, A3_M and Tnew_M.
- W stage holds A3_W. Tnew in W is always 0.

Per-cycle update (when reset=0):
- If stall=1, E loads a bubble: all fields 0. Otherwise E loads rs_D, rt_D, A3_D and Tnew_D.
- M loads rt_E and A3_E. Tnew_M = Tnew_E − 1, saturating at 0.
- W loads A3_M.
- stall_cnt increments when stall=1, unless it is already all-ones.

Stall (combinational):
- stall = stall_rs | stall_rt.
- stall_rs = (rs_D≠0) & [ (rs_D==A3_E & Tnew_E>Tuse_rs) | (rs_D==A3_M & Tnew_M>Tuse_rs) ].
- stall_rt is the same expression with rt and Tuse_rt.
- Tuse=3 never stalls, because Tnew ≤ 2.

Forwarding (combinational; register 0 is never forwarded; the youngest matching stage wins):
- FwdRsD: 11 if rs_D==A3_E & Tnew_E==0. Else 10 if rs_D==A3_M & Tnew_M==0. Else 01 if rs_D==A3_W. Else 00.
- FwdRtD: same as FwdRsD, using rt_D.
- FwdRsE: 10 if rs_E==A3_M & Tnew_M==0. Else 01 if rs_E==A3_W. Else 00.
- FwdRtE: same as FwdRsE, using rt_E.
- FwdRtM: 1 if rt_M==A3_W & rt_M≠0. Else 0.
- A forward select is don't-care whenever stall=1. The datapath discards that cycle.

Boundary rules:
- A3=0 in any stage matches nothing; writes to $0 are never forwarded or stalled on.
- A matching E-stage writer with Tnew_E>0 but Tnew_E ≤ Tuse produces neither a stall nor an E forward. The value is picked up later from M or W.
- Simultaneous matches in E and M: the stall decision ORs both; forwarding takes the E match.

## Timing
- stall and all Fwd* outputs are purely combinational from the current inputs and shadow state, with zero latency.
- Shadow state and stall_cnt update one cycle after the inputs are sampled.
- Reset:
  - All shadow registers clear to 0 on the first clock edge with reset=1; stall_cnt clears to 0.
  - Consequently, after reset stall=0, every Fwd* output is 00 (FwdRtM=0), and stall_cnt=0 regardless of D inputs.
  - A reset asserted mid-stall clears that stall on the next edge.
- A load-use hazard (lw followed by an ALU use, Tuse=1) produces exactly one stall cycle.
- A load followed by a branch (beq/jr, Tuse=0) produces two stall cycles.
- An ALU result followed by a branch produces one stall cycle.

## Test plan
- Reset, then hold rs_D=rt_D=5 with Tuse=0 and no prior writers → stall=0, all Fwd*=00, stall_cnt=0.
- lw $8 (A3_D=8, Tnew_D=2), then addu reading $8 (Tuse_rs=1):
  - stall=1 for 1 cycle.
  - Next cycle FwdRsE=01 (from W).
  - stall_cnt=1.
- lw $8, then beq reading $8 (Tuse_rs=0):
  - stall for 2 cycles.
  - Then FwdRsD=01.
  - stall_cnt=2.
- ori $9 (Tnew_D=1), then sw using $9 as rt (Tuse_rt=2):
  - No stall.
  - FwdRtE=10 the following cycle, then FwdRtM=1 in the cycle after that.
- jal writing $31 (Tnew_D=0), then jr $31 (Tuse_rs=0) → no stall; FwdRsD=11.
- addu writing $0, then a reader of $0 with Tuse=0 → stall=0 and Fwd*=00. Additionally, force stall continuously for 2^CNT_W cycles (bench with CNT_W=4) → stall_cnt saturates at 15.
